// File: rtl/siso_ctrl_pkg.sv
// Shared types and constants for the serial-out controller.
package siso_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int SISO_CTRL_WIDTH_DEF = 4;

endpackage

// File: rtl/siso_shift_core.sv
// Parallel-load, left-shifting register with MSB tap; cleared by reset.
module siso_shift_core
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = SISO_CTRL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic             msb
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= data_in;
    end else if (shift_en) begin
      sreg <= {sreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sreg[WIDTH-1];

endmodule

// File: rtl/siso_ctrl.sv
// Serialises a WIDTH-bit word MSB first; SISO_CTRL_PARITY_EN appends an even-parity bit.
module siso_ctrl
  import siso_ctrl_pkg::*;
#(
  parameter int WIDTH = SISO_CTRL_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] data_in,
  output logic             load_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             msb;

  assign accept = (state == IDLE) && load_valid;

  siso_shift_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .shift_en (state == SHIFT),
    .data_in  (data_in),
    .msb      (msb)
  );

`ifdef SISO_CTRL_PARITY_EN
  logic par;

  // Parity is taken from the captured word so it is ready when SHIFT ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (accept) begin
      par <= ^data_in;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state <= SHIFT;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (abort) begin
            state <= IDLE;
          end else if (cnt == LAST) begin
`ifdef SISO_CTRL_PARITY_EN
            state <= PARITY;
`else
            state <= DONE;
`endif
          end
        end
        PARITY: state <= abort ? IDLE : DONE;
        DONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign load_ready = (state == IDLE);
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
`ifdef SISO_CTRL_PARITY_EN
  assign ser_valid  = (state == SHIFT) || (state == PARITY);
  assign ser_out    = ((state == SHIFT) & msb) | ((state == PARITY) & par);
`else
  assign ser_valid  = (state == SHIFT);
  assign ser_out    = (state == SHIFT) & msb;
`endif

endmodule

// File: tb/tb_siso_ctrl.sv
// Scoreboard bench for siso_ctrl at WIDTH=4 and WIDTH=8; honours SISO_CTRL_PARITY_EN.
module tb_siso_ctrl;

`ifdef SISO_CTRL_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load_valid, abort;
  logic [3:0] data_in;
  logic       load_ready, ser_out, ser_valid, busy, done;

  logic       rst8, load_valid8, abort8;
  logic [7:0] data_in8;
  logic       load_ready8, ser_out8, ser_valid8, busy8, done8;

  siso_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .load_valid(load_valid), .data_in(data_in),
    .load_ready(load_ready), .abort(abort), .ser_out(ser_out),
    .ser_valid(ser_valid), .busy(busy), .done(done)
  );

  siso_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .load_valid(load_valid8), .data_in(data_in8),
    .load_ready(load_ready8), .abort(abort8), .ser_out(ser_out8),
    .ser_valid(ser_valid8), .busy(busy8), .done(done8)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit q4[$];
  bit q8[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push4(input logic [3:0] w);
    for (int i = 3; i >= 0; i--) q4.push_back(w[i]);
    if (PAR != 0) q4.push_back(^w);
  endtask

  // Serial bits are popped from the scoreboard whenever the DUT flags one.
  always @(negedge clk) begin
    if (!rst && ser_valid) begin
      if (q4.size() == 0) chk("sb4_unexpected_bit", 1, 0);
      else chk("sb4_ser_out", ser_out, q4.pop_front());
    end
    if (!rst8 && ser_valid8) begin
      if (q8.size() == 0) chk("sb8_unexpected_bit", 1, 0);
      else chk("sb8_ser_out", ser_out8, q8.pop_front());
    end
  end

  // Drive one word into dut4 and follow the frame through done back to IDLE.
  task automatic frame4(input logic [3:0] w, input string tag);
    chk({tag, "_ready"}, load_ready, 1);
    load_valid = 1'b1;
    data_in    = w;
    push4(w);
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 4 + PAR; c++) begin
      chk({tag, "_valid"}, ser_valid, 1);
      chk({tag, "_done_low"}, done, 0);
      step();
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_done_valid"}, ser_valid, 0);
    chk({tag, "_done_ready"}, load_ready, 0);
    step();
    chk({tag, "_idle_ready"}, load_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_sb_drained"}, q4.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_valid = 1'b0; abort = 1'b0; data_in = '0;
    rst8 = 1'b1; load_valid8 = 1'b0; abort8 = 1'b0; data_in8 = '0;
    repeat (2) step();
    chk("rst_ser_out", ser_out, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", load_ready, 1);
    rst = 1'b0; rst8 = 1'b0;
    step();

    frame4(4'b1101, "f1101");
    frame4(4'b1011, "f1011");
    frame4(4'b0000, "f0000");

    // Word offered during SHIFT must wait for the IDLE cycle after done.
    load_valid = 1'b1; data_in = 4'b1110; push4(4'b1110);
    step();
    data_in = 4'b0001;
    for (int c = 1; c <= 4 + PAR; c++) begin
      chk("hold_ready_low", load_ready, 0);
      step();
    end
    chk("hold_done", done, 1);
    step();
    chk("hold_idle_ready", load_ready, 1);
    push4(4'b0001);
    step();
    load_valid = 1'b0;
    chk("hold_second_busy", busy, 1);
    repeat (4 + PAR) step();
    chk("hold_second_done", done, 1);
    step();
    chk("hold_sb_drained", q4.size(), 0);

    // Abort during the second SHIFT cycle.
    load_valid = 1'b1; data_in = 4'b1111;
    q4.push_back(1'b1); q4.push_back(1'b1);
    step();
    load_valid = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_valid", ser_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", load_ready, 1);
    chk("abort_sb_drained", q4.size(), 0);
    for (int c = 0; c < 3; c++) begin
      chk("abort_no_done", done, 0);
      step();
    end

    // Abort together with load_valid in IDLE: load wins.
    abort = 1'b1; load_valid = 1'b1; data_in = 4'b0110; push4(4'b0110);
    step();
    abort = 1'b0; load_valid = 1'b0;
    chk("abort_idle_busy", busy, 1);
    repeat (4 + PAR) step();
    chk("abort_idle_done", done, 1);
    step();

    // Asynchronous reset between edges in the middle of SHIFT.
    load_valid = 1'b1; data_in = 4'b1111;
    q4.push_back(1'b1);
    step();
    load_valid = 1'b0;
    chk("mid_ser_out", ser_out, 1);
    #4;
    q4.delete();
    rst = 1'b1;
    #1;
    chk("async_ser_out", ser_out, 0);
    chk("async_valid", ser_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_ready", load_ready, 1);
    @(posedge clk); #2;
    rst = 1'b0;
    load_valid = 1'b1; data_in = 4'b0101; push4(4'b0101);
    @(posedge clk); #1;
    load_valid = 1'b0;
    chk("post_rst_busy", busy, 1);
    repeat (4 + PAR) step();
    chk("post_rst_done", done, 1);
    step();
    chk("post_rst_sb_drained", q4.size(), 0);

    // WIDTH=8 instance.
    load_valid8 = 1'b1; data_in8 = 8'hA5;
    for (int i = 7; i >= 0; i--) q8.push_back(data_in8[i]);
    if (PAR != 0) q8.push_back(^data_in8);
    step();
    load_valid8 = 1'b0;
    for (int c = 1; c <= 8 + PAR; c++) begin
      chk("w8_valid", ser_valid8, 1);
      step();
    end
    chk("w8_done", done8, 1);
    chk("w8_done_valid", ser_valid8, 0);
    step();
    chk("w8_ready", load_ready8, 1);
    chk("w8_sb_drained", q8.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
